// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB down-counting timer.
// Register offsets (PADDR[4:2]), CTRL bit indices, width defaults.
package apb_timer_pkg;

  localparam int PRESCALE_W_DEF = 16;
  localparam int CNT_W_DEF      = 32;

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_PRESC = 3'd1;
  localparam logic [2:0] OFF_LOAD  = 3'd2;
  localparam logic [2:0] OFF_COUNT = 3'd3;
  localparam logic [2:0] OFF_STAT  = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  function automatic logic is_mapped(input logic [2:0] off);
    return off <= OFF_STAT;
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler: pcnt counts 0..presc while en, pulses tick at the top.
// Ports: HCLK, HRESETN, en, presc, clr (restart) -> tick.
module apb_timer_prescaler
  import apb_timer_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] presc,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == presc);

  // A compare miss after a PRESC shrink wraps pcnt naturally.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      pcnt <= '0;
    end else if (clr || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB slave 32-bit down-counting timer with prescaler and level IRQ.
// Ports: HCLK/HRESETN, APB (PSEL..PSLVERR), TIMER_IRQ.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        TIMER_IRQ
);

  logic [2:0]            ctrl;
  logic [2:0]            ctrl_nxt;
  logic [PRESCALE_W-1:0] presc;
  logic [CNT_W-1:0]      load;
  logic [CNT_W-1:0]      count;
  logic                  exp_flag;

  logic [2:0]  idx;
  logic        mapped;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_presc;
  logic        wr_load;
  logic        wr_stat;
  logic        tick;
  logic        expire;
  logic [31:0] rdata;
  logic        unused_addr;

  assign idx         = PADDR[4:2];
  assign mapped      = is_mapped(idx);
  assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};

  assign wr       = PSEL && PENABLE && PWRITE;
  assign wr_ctrl  = wr && (idx == OFF_CTRL);
  assign wr_presc = wr && (idx == OFF_PRESC);
  assign wr_load  = wr && (idx == OFF_LOAD);
  assign wr_stat  = wr && (idx == OFF_STAT);

  apb_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .HCLK   (HCLK),
    .HRESETN(HRESETN),
    .en     (ctrl[CTRL_EN]),
    .presc  (presc),
    .clr    (wr_load),
    .tick   (tick)
  );

  // A LOAD write overrides whatever the tick would have done.
  assign expire = tick && (count == '0) && !wr_load;

  always_comb begin
    ctrl_nxt = ctrl;
    if (wr_ctrl) begin
      ctrl_nxt = PWDATA[2:0];
    end
    if (expire && !ctrl[CTRL_AUTO]) begin
      ctrl_nxt[CTRL_EN] = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      ctrl  <= '0;
      presc <= '0;
      load  <= '0;
    end else begin
      ctrl <= ctrl_nxt;
      if (wr_presc) begin
        presc <= PWDATA[PRESCALE_W-1:0];
      end
      if (wr_load) begin
        load <= PWDATA[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      count <= '0;
    end else if (wr_load) begin
      count <= PWDATA[CNT_W-1:0];
    end else if (expire) begin
      if (ctrl[CTRL_AUTO]) begin
        count <= load;
      end
    end else if (tick) begin
      count <= count - 1'b1;
    end
  end

  // Expiry set beats a simultaneous W1C.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      exp_flag <= 1'b0;
    end else if (expire) begin
      exp_flag <= 1'b1;
    end else if (wr_stat && PWDATA[0]) begin
      exp_flag <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      TIMER_IRQ <= 1'b0;
    end else begin
      TIMER_IRQ <= exp_flag && ctrl[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      OFF_CTRL:  rdata[2:0]            = ctrl;
      OFF_PRESC: rdata[PRESCALE_W-1:0] = presc;
      OFF_LOAD:  rdata[CNT_W-1:0]      = load;
      OFF_COUNT: rdata[CNT_W-1:0]      = count;
      OFF_STAT:  rdata[0]              = exp_flag;
      default:   rdata                 = '0;
    endcase
  end

  assign PRDATA  = (PSEL && !PWRITE) ? rdata : '0;
  assign PSLVERR = PSEL && PENABLE && !mapped;
  assign PREADY  = 1'b1;

endmodule

// File: tb/tb_apb_timer.sv
// Directed self-checking bench for apb_timer.
// One task per scenario, inline comparisons.
module tb_apb_timer;

  logic        HCLK;
  logic        HRESETN;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        TIMER_IRQ;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_PRESC = 32'h04;
  localparam logic [31:0] A_LOAD  = 32'h08;
  localparam logic [31:0] A_COUNT = 32'h0C;
  localparam logic [31:0] A_STAT  = 32'h10;
  localparam logic [31:0] A_BAD   = 32'h18;

  apb_timer dut (
    .HCLK     (HCLK),
    .HRESETN  (HRESETN),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .TIMER_IRQ(TIMER_IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1;
    @(posedge HCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    @(posedge HCLK); #1;
    PENABLE = 1; #1;
    d = PRDATA;
    @(posedge HCLK); #1;
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [5];
    addrs = '{A_CTRL, A_PRESC, A_LOAD, A_COUNT, A_STAT};
    HRESETN = 0;
    repeat (2) @(posedge HCLK);
    foreach (addrs[i]) begin
      apb_read(addrs[i], d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_rd[%0h] got %h want 0", addrs[i], d);
      end
    end
    n_cmp++;
    if (TIMER_IRQ !== 1'b0) begin
      n_bad++; $display("FAIL reset_irq got %b want 0", TIMER_IRQ);
    end
    n_cmp++;
    if (PREADY !== 1'b1) begin
      n_bad++; $display("FAIL reset_pready got %b want 1", PREADY);
    end
    n_cmp++;
    if (PSLVERR !== 1'b0) begin
      n_bad++; $display("FAIL reset_pslverr got %b want 0", PSLVERR);
    end
    @(posedge HCLK); #3;
    HRESETN = 1;
  endtask

  task automatic test_oneshot();
    apb_write(A_PRESC, 0);
    apb_write(A_LOAD, 3);
    apb_write(A_CTRL, 5);
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = A_COUNT; #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (PRDATA !== 32'(3 - k)) begin
        n_bad++;
        $display("FAIL os_count[%0d] got %0d want %0d", k, PRDATA, 3 - k);
      end
      @(posedge HCLK); #2;
    end
    n_cmp++;
    if (PRDATA !== 32'h0) begin
      n_bad++; $display("FAIL os_count_end got %0d want 0", PRDATA);
    end
    n_cmp++;
    if (TIMER_IRQ !== 1'b0) begin
      n_bad++; $display("FAIL os_irq_early got %b want 0", TIMER_IRQ);
    end
    PADDR = A_STAT; #1;
    n_cmp++;
    if (PRDATA !== 32'h1) begin
      n_bad++; $display("FAIL os_exp got %h want 1", PRDATA);
    end
    PADDR = A_CTRL; #1;
    n_cmp++;
    if (PRDATA !== 32'h4) begin
      n_bad++; $display("FAIL os_ctrl_en got %h want 4", PRDATA);
    end
    @(posedge HCLK); #1;
    n_cmp++;
    if (TIMER_IRQ !== 1'b1) begin
      n_bad++; $display("FAIL os_irq got %b want 1", TIMER_IRQ);
    end
    PADDR = A_COUNT; #1;
    n_cmp++;
    if (PRDATA !== 32'h0) begin
      n_bad++; $display("FAIL os_count_hold got %0d want 0", PRDATA);
    end
    PSEL = 0;
    apb_write(A_STAT, 1);
    apb_write(A_CTRL, 0);
    n_cmp++;
    if (TIMER_IRQ !== 1'b0) begin
      n_bad++; $display("FAIL os_irq_clr got %b want 0", TIMER_IRQ);
    end
  endtask

  task automatic test_autoreload();
    int cexp [6];
    cexp = '{2, 2, 1, 1, 0, 0};
    apb_write(A_PRESC, 1);
    apb_write(A_LOAD, 2);
    apb_write(A_CTRL, 3);
    for (int k = 0; k < 8; k++) begin
      PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = A_COUNT; #1;
      n_cmp++;
      if (PRDATA !== 32'(cexp[k % 6])) begin
        n_bad++;
        $display("FAIL ar_count[%0d] got %0d want %0d", k, PRDATA, cexp[k % 6]);
      end
      PADDR = A_STAT; #1;
      n_cmp++;
      if (PRDATA[0] !== (k >= 6)) begin
        n_bad++;
        $display("FAIL ar_exp[%0d] got %b want %b", k, PRDATA[0], k >= 6);
      end
      @(posedge HCLK); #1;
    end
    apb_write(A_STAT, 1);
    PSEL = 1; PWRITE = 0; PADDR = A_STAT; #1;
    n_cmp++;
    if (PRDATA !== 32'h0) begin
      n_bad++; $display("FAIL ar_w1c got %h want 0", PRDATA);
    end
    @(posedge HCLK); #1;
    n_cmp++;
    if (PRDATA !== 32'h1) begin
      n_bad++; $display("FAIL ar_exp2 got %h want 1", PRDATA);
    end
    PADDR = A_COUNT; #1;
    n_cmp++;
    if (PRDATA !== 32'h2) begin
      n_bad++; $display("FAIL ar_reload got %0d want 2", PRDATA);
    end
    PSEL = 0;
  endtask

  task automatic test_collisions();
    repeat (3) @(posedge HCLK);
    #1;
    apb_write(A_STAT, 1);
    PSEL = 1; PWRITE = 0; PADDR = A_STAT; #1;
    n_cmp++;
    if (PRDATA !== 32'h1) begin
      n_bad++; $display("FAIL col_w1c_exp got %h want 1", PRDATA);
    end
    PSEL = 0;
    @(posedge HCLK); #1;
    apb_write(A_LOAD, 9);
    PSEL = 1; PWRITE = 0; PADDR = A_COUNT; #1;
    n_cmp++;
    if (PRDATA !== 32'd9) begin
      n_bad++; $display("FAIL col_load_tick got %0d want 9", PRDATA);
    end
    @(posedge HCLK); #1;
    n_cmp++;
    if (PRDATA !== 32'd9) begin
      n_bad++; $display("FAIL col_load_hold got %0d want 9", PRDATA);
    end
    @(posedge HCLK); #1;
    n_cmp++;
    if (PRDATA !== 32'd8) begin
      n_bad++; $display("FAIL col_load_dec got %0d want 8", PRDATA);
    end
    PSEL = 0;
    apb_write(A_CTRL, 0);
    apb_write(A_STAT, 1);
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [31:0] addrs [5];
    logic [31:0] want [5];
    apb_write(A_LOAD, 7);
    apb_write(A_COUNT, 32'h55);
    @(posedge HCLK); #1;
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = A_BAD; #1;
    n_cmp++;
    if (PSLVERR !== 1'b0) begin
      n_bad++; $display("FAIL um_setup_err got %b want 0", PSLVERR);
    end
    @(posedge HCLK); #1;
    PENABLE = 1; #1;
    n_cmp++;
    if (PSLVERR !== 1'b1 || PRDATA !== 32'h0) begin
      n_bad++;
      $display("FAIL um_rd err=%b data=%h want 1/0", PSLVERR, PRDATA);
    end
    n_cmp++;
    if (PREADY !== 1'b1) begin
      n_bad++; $display("FAIL um_pready got %b want 1", PREADY);
    end
    @(posedge HCLK); #1;
    PSEL = 1; PWRITE = 1; PENABLE = 0; PWDATA = 32'hFFFF_FFFF;
    @(posedge HCLK); #1;
    PENABLE = 1; #1;
    n_cmp++;
    if (PSLVERR !== 1'b1) begin
      n_bad++; $display("FAIL um_wr_err got %b want 1", PSLVERR);
    end
    @(posedge HCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    addrs = '{A_CTRL, A_PRESC, A_LOAD, A_COUNT, A_STAT};
    want  = '{32'h0, 32'h1, 32'h7, 32'h7, 32'h0};
    foreach (addrs[i]) begin
      apb_read(addrs[i], d);
      n_cmp++;
      if (d !== want[i]) begin
        n_bad++;
        $display("FAIL um_keep[%0h] got %h want %h", addrs[i], d, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] addrs [5];
    addrs = '{A_CTRL, A_PRESC, A_LOAD, A_COUNT, A_STAT};
    apb_write(A_PRESC, 0);
    apb_write(A_LOAD, 0);
    apb_write(A_CTRL, 5);
    apb_write(A_LOAD, 5);
    apb_write(A_PRESC, 3);
    apb_read(A_STAT, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_bad++; $display("FAIL rm_pre_exp got %h want 1", d);
    end
    n_cmp++;
    if (TIMER_IRQ !== 1'b1) begin
      n_bad++; $display("FAIL rm_pre_irq got %b want 1", TIMER_IRQ);
    end
    apb_write(A_CTRL, 7);
    PSEL = 1; PWRITE = 0; PADDR = A_COUNT; #1;
    n_cmp++;
    if (PRDATA !== 32'd5) begin
      n_bad++; $display("FAIL rm_pre_count got %0d want 5", PRDATA);
    end
    PSEL = 0;
    repeat (2) @(posedge HCLK);
    #3;
    HRESETN = 0; #1;
    n_cmp++;
    if (TIMER_IRQ !== 1'b0) begin
      n_bad++; $display("FAIL rm_irq got %b want 0", TIMER_IRQ);
    end
    foreach (addrs[i]) begin
      apb_read(addrs[i], d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_bad++;
        $display("FAIL rm_rd[%0h] got %h want 0", addrs[i], d);
      end
    end
    @(posedge HCLK); #3;
    HRESETN = 1;
    repeat (10) @(posedge HCLK);
    foreach (addrs[i]) begin
      apb_read(addrs[i], d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_bad++;
        $display("FAIL rm_idle[%0h] got %h want 0", addrs[i], d);
      end
    end
    n_cmp++;
    if (TIMER_IRQ !== 1'b0) begin
      n_bad++; $display("FAIL rm_idle_irq got %b want 0", TIMER_IRQ);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    HRESETN = 0;
    PSEL    = 0;
    PENABLE = 0;
    PWRITE  = 0;
    PADDR   = '0;
    PWDATA  = '0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_collisions();
    test_unmapped();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
